// File: rtl/spi_pwm_cmd_ctrl.sv
// Command controller between the SPI slave and the PWM channel bank:
// word decode, per-channel duty/enable registers, MISO word selection and watchdog.
module spi_pwm_cmd_ctrl #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned DUTY_W     = 8,
   parameter int unsigned WDT_CYCLES = 50_000_000,
   parameter int unsigned WDT_W      = 26
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [15:0]             word_in,
   input  logic                    word_strobe,
   input  logic                    ssel_active,
   input  logic [39:0]             hym_data,
   input  logic                    hym_valid,
   output logic [39:0]             tx_word,
   output logic [NCH*DUTY_W-1:0]   duty,
   output logic [NCH-1:0]          ch_en,
   output logic                    wdt_expired,
   output logic                    cmd_err
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_idx, w_idx_nxt;
   logic [1:0]          r_tx_sel;
   logic [39:0]         r_hym;
   logic [15:0]         r_word_cnt;
   logic [7:0]          r_err_cnt;
   logic [WDT_W-1:0]    r_wdt_cnt;

   logic [3:0]          w_op, w_arg;
   logic [7:0]          w_data;
   logic                w_trip;
   logic                w_duty_we, w_en_we, w_sel_we, w_err;
   logic [3:0]          w_duty_sel;
   logic [39:0]         w_tx_src;

   assign w_op   = word_in[15:12];
   assign w_arg  = word_in[11:8];
   assign w_data = word_in[7:0];

   // A strobe landing in the trip cycle clears the counter, so it suppresses the trip
   assign w_trip = !word_strobe && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (w_trip) begin
         w_state_nxt = S_IDLE;
      end else if (word_strobe) begin
         case (r_state)
            S_IDLE: begin
               if (w_op == 4'h4) begin
                  w_state_nxt = S_BURST;
                  w_idx_nxt   = '0;
               end
            end
            S_BURST: begin
               if (r_idx == 2'(NCH - 1)) w_state_nxt = S_IDLE;
               else                      w_idx_nxt   = r_idx + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_duty_we  = 1'b0;
      w_duty_sel = '0;
      w_en_we    = 1'b0;
      w_sel_we   = 1'b0;
      w_err      = 1'b0;
      if (word_strobe) begin
         if (r_state == S_BURST) begin
            w_duty_we  = 1'b1;
            w_duty_sel = {2'b00, r_idx};
         end else begin
            case (w_op)
               4'h0: ;
               4'h1: begin
                  if (w_arg < 4'(NCH)) begin
                     w_duty_we  = 1'b1;
                     w_duty_sel = w_arg;
                  end else begin
                     w_err = 1'b1;
                  end
               end
               4'h2: w_en_we = 1'b1;
               4'h3: begin
                  if (w_data[1:0] == 2'd3) w_err    = 1'b1;
                  else                     w_sel_we = 1'b1;
               end
               4'h4: ;
               default: w_err = 1'b1;
            endcase
         end
      end
   end

   always_comb begin
      case (r_tx_sel)
         2'd0:    w_tx_src = r_hym;
         2'd1:    w_tx_src = {8'hD0, 32'(duty)};
         2'd2:    w_tx_src = {8'h5A, r_word_cnt, r_err_cnt, 3'b000, wdt_expired, 4'(ch_en)};
         default: w_tx_src = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_word     <= '0;
         duty        <= '0;
         ch_en       <= '0;
         wdt_expired <= 1'b0;
         cmd_err     <= 1'b0;
         r_tx_sel    <= '0;
         r_hym       <= '0;
         r_word_cnt  <= '0;
         r_err_cnt   <= '0;
         r_wdt_cnt   <= '0;
      end else begin
         cmd_err <= w_err;
         if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
         if (word_strobe) r_word_cnt <= r_word_cnt + 1'b1;

         for (int unsigned c = 0; c < NCH; c++) begin
            if (w_duty_we && w_duty_sel == 4'(c)) duty[c*DUTY_W +: DUTY_W] <= w_data;
         end

         if (w_trip)       ch_en <= '0;
         else if (w_en_we) ch_en <= w_data[NCH-1:0];

         if (word_strobe) begin
            r_wdt_cnt   <= '0;
            wdt_expired <= 1'b0;
         end else if (w_trip) begin
            wdt_expired <= 1'b1;
         end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
         end

         if (w_sel_we)  r_tx_sel <= w_data[1:0];
         if (hym_valid) r_hym    <= hym_data;
         if (!ssel_active) tx_word <= w_tx_src;
      end
   end

endmodule
